// File: rtl/cache_trace_driver_if.sv
// rtl/cache_trace_driver_if.sv - request/response bundle between the trace driver and the data cache
interface cache_trace_driver_if #(
  parameter int ADDRESSL = 15,
  parameter int WORD     = 32
);
  logic                req;
  logic [ADDRESSL-1:0] address;
  logic                ready;
  logic [WORD-1:0]     dataIn;
  logic [ADDRESSL-1:0] numOfHits;

  // The trace driver issues requests and consumes the cache's response and hit count.
  modport master (
    output req,
    output address,
    input  ready,
    input  dataIn,
    input  numOfHits
  );

  // The cache side answers requests and reports its running hit count.
  modport slave (
    input  req,
    input  address,
    output ready,
    output dataIn,
    output numOfHits
  );
endinterface

// File: rtl/cache_trace_driver.sv
// rtl/cache_trace_driver.sv - linear address trace sequencer with checksum and hit-count capture
module cache_trace_driver #(
  parameter int ADDRESSL     = 15,
  parameter int WORD         = 32,
  parameter int START_ADR    = 1024,
  parameter int NUM_ACCESSES = 8192,
  parameter int TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  cache_trace_driver_if.master  cache,
  output logic                  busy,
  output logic                  done,
  output logic                  timeoutErr,
  output logic [ADDRESSL:0]     accessCount,
  output logic [WORD-1:0]       checksum,
  output logic [ADDRESSL-1:0]   hitsLatched
);

  // First address of the trace, truncated to the address width.
  localparam logic [ADDRESSL-1:0] START_VAL = ADDRESSL'(START_ADR);
  // Access count that ends a run; one extra bit so 2^ADDRESSL fits.
  localparam logic [ADDRESSL:0]   LAST_CNT  = (ADDRESSL+1)'(NUM_ACCESSES);
  // The wait counter starts at 0 in the first WAIT cycle, so the abort fires
  // on the TIMEOUT-th consecutive WAIT cycle without ready.
  localparam logic [7:0]          WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t              state_q;
  state_t              state_d;

  logic [ADDRESSL-1:0] addr_q;
  logic [ADDRESSL:0]   acnt_q;
  logic [WORD-1:0]     csum_q;
  logic                terr_q;
  logic [ADDRESSL-1:0] hits_q;
  logic [7:0]          wait_cnt_q;

  logic                load_run;
  logic                take_word;
  logic                timeout_hit;
  logic                step_addr;
  logic                enter_done;
  logic                wait_miss;

  // State register; reset dominates every other input, including mid-run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode plus the one-cycle strobes that steer the datapath.
  always_comb begin
    state_d     = state_q;
    load_run    = 1'b0;
    take_word   = 1'b0;
    timeout_hit = 1'b0;
    step_addr   = 1'b0;
    enter_done  = 1'b0;
    wait_miss   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          load_run = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cache.ready) begin
          take_word = 1'b1;
          state_d   = S_NEXT;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_hit = 1'b1;
          enter_done  = 1'b1;
          state_d     = S_DONE;
        end else begin
          wait_miss = 1'b1;
        end
      end
      S_NEXT: begin
        if (acnt_q == LAST_CNT) begin
          enter_done = 1'b1;
          state_d    = S_DONE;
        end else begin
          step_addr = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Trace address: loaded at run start, advanced between accesses, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else if (load_run) begin
      addr_q <= START_VAL;
    end else if (step_addr) begin
      addr_q <= addr_q + 1'b1;
    end
  end

  // Completed-access counter and running checksum; carry out of the sum is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      acnt_q <= '0;
      csum_q <= '0;
    end else if (load_run) begin
      acnt_q <= '0;
      csum_q <= '0;
    end else if (take_word) begin
      acnt_q <= acnt_q + 1'b1;
      csum_q <= csum_q + cache.dataIn;
    end
  end

  // Ready wait counter: cleared while the request is out, counts idle WAIT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_ISSUE) begin
      wait_cnt_q <= '0;
    end else if (wait_miss) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  // Abort flag: set when the cache never answers, cleared by the next run.
  always_ff @(posedge clk) begin
    if (rst) begin
      terr_q <= 1'b0;
    end else if (load_run) begin
      terr_q <= 1'b0;
    end else if (timeout_hit) begin
      terr_q <= 1'b1;
    end
  end

  // Snapshot of the cache hit counter taken on every entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q <= '0;
    end else if (enter_done) begin
      hits_q <= cache.numOfHits;
    end
  end

  assign cache.req     = (state_q == S_ISSUE);
  assign cache.address = addr_q;
  assign busy          = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_NEXT);
  assign done          = (state_q == S_DONE);
  assign timeoutErr    = terr_q;
  assign accessCount   = acnt_q;
  assign checksum      = csum_q;
  assign hitsLatched   = hits_q;

endmodule

// File: tb/tb_cache_trace_driver.sv
// tb/tb_cache_trace_driver.sv - directed scoreboard bench for cache_trace_driver
module tb_cache_trace_driver;
  localparam int AW = 15;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic start [3];
  logic busy [3];
  logic done [3];
  logic terr [3];
  logic [AW:0]   acnt [3];
  logic [DW-1:0] csum [3];
  logic [AW-1:0] hits [3];
  logic [AW-1:0] nhits;

  logic          m_ready [3];
  logic [DW-1:0] m_data [3];
  logic [2:0]    m_req;
  logic [AW-1:0] m_addr [3];
  int            m_mode [3];
  int            m_dly [3];
  int            req_seen [3];
  int            req_cyc [3];

  logic [AW-1:0] exp_q [$];
  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  cache_trace_driver_if #(.ADDRESSL(AW), .WORD(DW)) if_a ();
  cache_trace_driver_if #(.ADDRESSL(AW), .WORD(DW)) if_b ();
  cache_trace_driver_if #(.ADDRESSL(AW), .WORD(DW)) if_c ();

  assign if_a.ready = m_ready[0];
  assign if_b.ready = m_ready[1];
  assign if_c.ready = m_ready[2];
  assign if_a.dataIn = m_data[0];
  assign if_b.dataIn = m_data[1];
  assign if_c.dataIn = m_data[2];
  assign if_a.numOfHits = nhits;
  assign if_b.numOfHits = nhits;
  assign if_c.numOfHits = nhits;
  assign m_req[0] = if_a.req;
  assign m_req[1] = if_b.req;
  assign m_req[2] = if_c.req;
  assign m_addr[0] = if_a.address;
  assign m_addr[1] = if_b.address;
  assign m_addr[2] = if_c.address;

  cache_trace_driver #(.ADDRESSL(AW), .WORD(DW), .START_ADR(1024), .NUM_ACCESSES(4), .TIMEOUT(10)) u_a (
    .clk(clk), .rst(rst), .start(start[0]), .cache(if_a),
    .busy(busy[0]), .done(done[0]), .timeoutErr(terr[0]),
    .accessCount(acnt[0]), .checksum(csum[0]), .hitsLatched(hits[0])
  );

  cache_trace_driver #(.ADDRESSL(AW), .WORD(DW), .START_ADR(32'h7FFE), .NUM_ACCESSES(3), .TIMEOUT(10)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .cache(if_b),
    .busy(busy[1]), .done(done[1]), .timeoutErr(terr[1]),
    .accessCount(acnt[1]), .checksum(csum[1]), .hitsLatched(hits[1])
  );

  cache_trace_driver #(.ADDRESSL(AW), .WORD(DW), .START_ADR(0), .NUM_ACCESSES(2), .TIMEOUT(10)) u_c (
    .clk(clk), .rst(rst), .start(start[2]), .cache(if_c),
    .busy(busy[2]), .done(done[2]), .timeoutErr(terr[2]),
    .accessCount(acnt[2]), .checksum(csum[2]), .hitsLatched(hits[2])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, score requests, then drive the cache model.
  // Model: ready for one cycle, 2 cycles after req; mode 0 never answers,
  // mode 1 returns the address, mode 2 returns all ones.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (m_req[i]) begin
        chk("req_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk("req_addr", 64'(m_addr[i]), 64'(exp_q.pop_front()));
        if (req_seen[i] > 0 && m_mode[i] != 0) chk("req_period", 64'(cyc - req_cyc[i]), 64'd4);
        req_seen[i]++;
        req_cyc[i] = cyc;
        m_dly[i]   = 2;
        m_ready[i] = 1'b0;
      end else if (m_dly[i] > 0) begin
        m_dly[i]--;
        m_ready[i] = (m_dly[i] == 0) && (m_mode[i] != 0);
        m_data[i]  = (m_mode[i] == 2) ? 32'hFFFF_FFFF : DW'(m_addr[i]);
      end else begin
        m_ready[i] = 1'b0;
      end
    end
  endtask

  task automatic begin_run(input int i);
    req_seen[i] = 0;
    m_dly[i]    = 0;
    start[i]    = 1'b1;
    step();
    start[i]    = 1'b0;
  endtask

  task automatic run_wait(input int i, input int budget);
    int n = 0;
    while (!done[i] && n < budget) begin
      step();
      n++;
    end
    chk("done_reached", 64'(done[i]), 64'd1);
  endtask

  initial begin
    rst   = 1'b1;
    nhits = '0;
    for (int i = 0; i < 3; i++) begin
      start[i]    = 1'b1;
      m_ready[i]  = 1'b0;
      m_data[i]   = '0;
      m_mode[i]   = 1;
      m_dly[i]    = 0;
      req_seen[i] = 0;
      req_cyc[i]  = 0;
    end

    // Reset held 2 cycles with start asserted.
    step();
    step();
    chk("rst_req",   64'(m_req[0]),  64'd0);
    chk("rst_addr",  64'(m_addr[0]), 64'd0);
    chk("rst_busy",  64'(busy[0]),   64'd0);
    chk("rst_done",  64'(done[0]),   64'd0);
    chk("rst_terr",  64'(terr[0]),   64'd0);
    chk("rst_acnt",  64'(acnt[0]),   64'd0);
    chk("rst_csum",  64'(csum[0]),   64'd0);
    chk("rst_hits",  64'(hits[0]),   64'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    step();
    for (int i = 0; i < 3; i++) chk("idle_after_rst", 64'(busy[i] | done[i]), 64'd0);

    // Four-access run from 1024, data = address.
    nhits = 15'd21;
    for (int a = 1024; a < 1028; a++) exp_q.push_back(AW'(a));
    begin_run(0);
    run_wait(0, 100);
    chk("a_csum",  64'(csum[0]), 64'd4102);
    chk("a_acnt",  64'(acnt[0]), 64'd4);
    chk("a_terr",  64'(terr[0]), 64'd0);
    chk("a_hits",  64'(hits[0]), 64'd21);
    chk("a_queue", 64'(exp_q.size()), 64'd0);
    step();
    step();
    step();
    chk("a_hold_done", 64'(done[0]),   64'd1);
    chk("a_hold_busy", 64'(busy[0]),   64'd0);
    chk("a_hold_addr", 64'(m_addr[0]), 64'd1027);
    chk("a_hold_acnt", 64'(acnt[0]),   64'd4);
    chk("a_hold_csum", 64'(csum[0]),   64'd4102);

    // Address wrap at the top of the address space.
    exp_q.push_back(15'h7FFE);
    exp_q.push_back(15'h7FFF);
    exp_q.push_back(15'h0000);
    begin_run(1);
    run_wait(1, 100);
    chk("b_csum",  64'(csum[1]),   64'hFFFD);
    chk("b_acnt",  64'(acnt[1]),   64'd3);
    chk("b_addr",  64'(m_addr[1]), 64'd0);
    chk("b_queue", 64'(exp_q.size()), 64'd0);

    // Cache never answers: abort after 10 idle WAIT cycles.
    m_mode[0] = 0;
    nhits     = 15'd9;
    exp_q.push_back(15'd1024);
    begin_run(0);
    run_wait(0, 100);
    chk("to_latency", 64'(cyc - req_cyc[0]), 64'd11);
    chk("to_terr",    64'(terr[0]), 64'd1);
    chk("to_acnt",    64'(acnt[0]), 64'd0);
    chk("to_csum",    64'(csum[0]), 64'd0);
    chk("to_hits",    64'(hits[0]), 64'd9);

    // Restart clears the abort flag; start in WAIT ignored; reset mid-access wins over ready.
    m_mode[0] = 1;
    exp_q.push_back(15'd1024);
    exp_q.push_back(15'd1025);
    begin_run(0);
    chk("terr_cleared", 64'(terr[0]), 64'd0);
    for (int n = 0; n < 50 && req_seen[0] < 2; n++) step();
    chk("second_req", 64'(req_seen[0]), 64'd2);
    step();
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    chk("wait_start_addr", 64'(m_addr[0]), 64'd1025);
    chk("wait_start_acnt", 64'(acnt[0]),   64'd1);
    chk("wait_start_busy", 64'(busy[0]),   64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_req",  64'(m_req[0]),  64'd0);
    chk("mid_rst_addr", 64'(m_addr[0]), 64'd0);
    chk("mid_rst_busy", 64'(busy[0]),   64'd0);
    chk("mid_rst_acnt", 64'(acnt[0]),   64'd0);
    chk("mid_rst_csum", 64'(csum[0]),   64'd0);
    chk("mid_rst_done", 64'(done[0]),   64'd0);
    step();
    chk("mid_rst_idle",  64'(busy[0] | done[0]), 64'd0);
    chk("mid_rst_queue", 64'(exp_q.size()), 64'd0);

    // Checksum carry drop and hit-count capture.
    m_mode[2] = 2;
    nhits     = 15'd37;
    exp_q.push_back(15'd0);
    exp_q.push_back(15'd1);
    begin_run(2);
    run_wait(2, 100);
    chk("c_csum",  64'(csum[2]), 64'hFFFF_FFFE);
    chk("c_acnt",  64'(acnt[2]), 64'd2);
    chk("c_hits",  64'(hits[2]), 64'd37);
    chk("c_terr",  64'(terr[2]), 64'd0);
    chk("c_queue", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
